// File: rtl/syndrome_byte_packer_pkg.sv
// Shared definitions for the syndrome byte packer: packer state encoding,
// default frame header and the round-to-byte sizing helpers.
package syndrome_byte_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } packer_state_t;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'h01;

    function automatic int bytes_per_round(input int pu_count);
        return (pu_count + 7) / 8;
    endfunction

    // Counter width that stays at least one bit wide for single-entry ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/syndrome_byte_packer_round_fifo.sv
// Single-clock round FIFO. Besides the usual flags it exposes the head and
// emptiness as they will be after the current edge, so the packer can
// register its next output byte without a bubble.
module syndrome_byte_packer_round_fifo #(
    parameter int WIDTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_empty_nxt,
    output logic [WIDTH-1:0] o_head_nxt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_inc;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign o_full       = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign w_push       = i_push && !o_full;
    assign w_pop        = i_pop && !o_empty;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    assign o_empty_nxt = (w_count_nxt == '0);

    // When the entry that becomes head is the one being pushed, forward it.
    always_comb begin
        o_head_nxt = r_mem[r_rd_ptr];
        if (w_pop) begin
            if (r_count > (DEPTH_LOG2 + 1)'(1)) begin
                o_head_nxt = r_mem[w_rd_ptr_inc];
            end else begin
                o_head_nxt = i_data;
            end
        end else if (o_empty) begin
            o_head_nxt = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/syndrome_byte_packer.sv
// Buffers measurement rounds and serialises each frame of GRID_WIDTH_U rounds
// into a header byte followed by the zero-padded round bytes.
module syndrome_byte_packer
    import syndrome_byte_packer_pkg::*;
#(
    parameter int         GRID_WIDTH_X    = 4,
    parameter int         GRID_WIDTH_Z    = 1,
    parameter int         GRID_WIDTH_U    = 3,
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0] HEADER_BYTE     = HEADER_BYTE_DEFAULT
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] i_round_data,
    input  logic                                 i_round_valid,
    output logic                                 o_round_ready,
    output logic [7:0]                           o_output_data,
    output logic                                 o_output_valid,
    input  logic                                 i_output_ready,
    output logic [15:0]                          o_frame_count,
    output logic                                 o_busy,
    output packer_state_t                        o_state
);

    localparam int PU_COUNT_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND    = bytes_per_round(PU_COUNT_PER_ROUND);
    localparam int BYTE_W             = cnt_width(BYTES_PER_ROUND);
    localparam int ROUND_W            = cnt_width(GRID_WIDTH_U);
    localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(BYTES_PER_ROUND - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(GRID_WIDTH_U - 1);

    packer_state_t                 r_state;
    logic [ROUND_W-1:0]            r_round;
    logic [BYTE_W-1:0]             r_byte;
    logic [7:0]                    r_data;
    logic                          r_valid;
    logic [15:0]                   r_frame_count;
    logic                          r_ready_en;

    logic                          w_push;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_empty_nxt;
    logic [PU_COUNT_PER_ROUND-1:0] w_head_nxt;
    logic [8*BYTES_PER_ROUND-1:0]  w_head_pad;
    logic [7:0]                    w_sel_byte;
    logic [BYTE_W-1:0]             w_byte_nxt;
    logic                          w_accept;
    logic                          w_last_byte;
    logic                          w_last_round;

    // Ready is held low until the first clock after reset is released.
    assign o_round_ready = r_ready_en && !w_full;
    assign w_push        = i_round_valid && o_round_ready;
    assign w_accept      = r_valid && i_output_ready;
    assign w_last_byte   = (r_byte == LAST_BYTE);
    assign w_last_round  = (r_round == LAST_ROUND);
    assign w_pop         = (r_state == ST_DATA) && w_accept && w_last_byte;

    syndrome_byte_packer_round_fifo #(
        .WIDTH      (PU_COUNT_PER_ROUND),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_round_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_data      (i_round_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_empty_nxt (w_empty_nxt),
        .o_head_nxt  (w_head_nxt)
    );

    always_comb begin
        w_byte_nxt = r_byte;
        if (r_state == ST_HEADER) begin
            w_byte_nxt = '0;
        end else if ((r_state == ST_DATA) && w_accept) begin
            w_byte_nxt = w_last_byte ? '0 : r_byte + 1'b1;
        end
    end

    always_comb begin
        w_head_pad = '0;
        w_head_pad[PU_COUNT_PER_ROUND-1:0] = w_head_nxt;
    end

    always_comb begin
        w_sel_byte = '0;
        for (int b = 0; b < BYTES_PER_ROUND; b++) begin
            if (w_byte_nxt == BYTE_W'(b)) begin
                w_sel_byte = w_head_pad[8*b +: 8];
            end
        end
    end

    // Output register reloads only when empty or just accepted, so a stalled
    // byte never changes or retracts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_round       <= '0;
            r_byte        <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_count <= '0;
            r_ready_en    <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    r_round <= '0;
                    r_byte  <= '0;
                    if (!w_empty) begin
                        r_state <= ST_HEADER;
                        r_data  <= HEADER_BYTE;
                        r_valid <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (w_accept) begin
                        r_state <= ST_DATA;
                        r_round <= '0;
                        r_byte  <= '0;
                        r_valid <= !w_empty_nxt;
                        r_data  <= w_sel_byte;
                    end
                end
                ST_DATA: begin
                    if (w_accept && w_last_byte && w_last_round) begin
                        r_state       <= ST_IDLE;
                        r_round       <= '0;
                        r_byte        <= '0;
                        r_valid       <= 1'b0;
                        r_data        <= '0;
                        r_frame_count <= r_frame_count + 16'd1;
                    end else if (w_accept || !r_valid) begin
                        r_byte  <= w_byte_nxt;
                        r_valid <= !w_empty_nxt;
                        r_data  <= w_sel_byte;
                        if (w_accept && w_last_byte) begin
                            r_round <= r_round + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_output_data  = r_data;
    assign o_output_valid = r_valid;
    assign o_frame_count  = r_frame_count;
    assign o_busy         = !w_empty || (r_state != ST_IDLE);
    assign o_state        = r_state;

endmodule

// File: tb/tb_syndrome_byte_packer.sv
// Directed bench for the syndrome byte packer: default 4x1x3 grid plus a
// 5x2x1 instance for the multi-byte round case.
module tb_syndrome_byte_packer;
    import syndrome_byte_packer_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    round_data = '0;
    logic          round_valid = 1'b0;
    logic          round_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   frame_count;
    logic          busy;
    packer_state_t state;

    logic [9:0]    b_round_data = '0;
    logic          b_round_valid = 1'b0;
    logic          b_round_ready;
    logic [7:0]    b_out_data;
    logic          b_out_valid;
    logic          b_out_ready = 1'b0;
    logic [15:0]   b_frame_count;
    logic          b_busy;
    packer_state_t b_state;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [7:0]    rx_q[$];
    int            rx_t[$];
    logic [7:0]    rxb_q[$];
    logic [7:0]    exp_q[$];
    logic          stall_prev = 1'b0;
    logic [7:0]    stall_data = '0;

    syndrome_byte_packer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_round_data   (round_data),
        .i_round_valid  (round_valid),
        .o_round_ready  (round_ready),
        .o_output_data  (out_data),
        .o_output_valid (out_valid),
        .i_output_ready (out_ready),
        .o_frame_count  (frame_count),
        .o_busy         (busy),
        .o_state        (state)
    );

    syndrome_byte_packer #(
        .GRID_WIDTH_X (5),
        .GRID_WIDTH_Z (2),
        .GRID_WIDTH_U (1)
    ) dut_b (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_round_data   (b_round_data),
        .i_round_valid  (b_round_valid),
        .o_round_ready  (b_round_ready),
        .o_output_data  (b_out_data),
        .o_output_valid (b_out_valid),
        .i_output_ready (b_out_ready),
        .o_frame_count  (b_frame_count),
        .o_busy         (b_busy),
        .o_state        (b_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Byte collection and the hold-while-stalled rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            rx_t.push_back(cyc);
        end
        if (b_out_valid && b_out_ready) begin
            rxb_q.push_back(b_out_data);
        end
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                assert (out_valid === 1'b1 && out_data === stall_data) else begin
                    failures++;
                    $error("FAIL hold: observed valid=%0b data=%0h expected valid=1 data=%0h",
                           out_valid, out_data, stall_data);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s: timed out waiting for the DUT", tag);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (rx_q.size() < n) timeout_fail(tag);
    endtask

    task automatic push_round(input logic [3:0] d);
        int k = 0;
        round_data  = d;
        round_valid = 1'b1;
        while (!round_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!round_ready) timeout_fail("push_round");
        @(posedge clk);
        #1;
        round_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        round_valid   = 1'b0;
        out_ready     = 1'b0;
        b_round_valid = 1'b0;
        b_out_ready   = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_frame_count", frame_count, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", state, ST_IDLE);
        chk("rst_round_ready", round_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_before_clk", round_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_ready_after_clk", round_ready, 1'b1);
    endtask

    initial begin
        int k;

        do_reset();

        // Basic 4x1x3 frame with the latency of the header.
        rx_q.delete();
        rx_t.delete();
        out_ready = 1'b1;
        push_round(4'b1010);
        @(negedge clk);
        chk("t1_idle_valid", out_valid, 1'b0);
        chk("t1_idle_busy", busy, 1'b1);
        push_round(4'b1010);
        chk("t1_hdr_valid", out_valid, 1'b1);
        chk("t1_hdr_data", out_data, 8'h01);
        chk("t1_hdr_state", state, ST_HEADER);
        push_round(4'b1010);
        wait_rx(4, "t1_wait");
        exp_q = '{8'h01, 8'h0A, 8'h0A, 8'h0A};
        check_bytes("t1");
        if (rx_t.size() >= 4) chk("t1_throughput", rx_t[3] - rx_t[0], 3);
        repeat (2) @(negedge clk);
        chk("t1_end_valid", out_valid, 1'b0);
        chk("t1_frame_count", frame_count, 16'd1);
        chk("t1_end_busy", busy, 1'b0);
        chk("t1_end_state", state, ST_IDLE);

        // 10-bit rounds split into two bytes, upper byte zero-padded.
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        chk("t2_round_ready", b_round_ready, 1'b1);
        b_round_data  = 10'h3FF;
        b_round_valid = 1'b1;
        @(posedge clk);
        #1;
        b_round_valid = 1'b0;
        k = 0;
        while (rxb_q.size() < 3 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (rxb_q.size() < 3) timeout_fail("t2_wait");
        repeat (2) @(negedge clk);
        rx_q  = rxb_q;
        exp_q = '{8'h01, 8'hFF, 8'h03};
        check_bytes("t2");
        chk("t2_frame_count", b_frame_count, 16'd1);
        rx_q.delete();

        // Header held for five stalled cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_round(4'b0110);
        push_round(4'b0011);
        push_round(4'b1100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_data%0d", i), out_data, 8'h01);
            chk($sformatf("t3_hold_valid%0d", i), out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_rx(4, "t3_wait");
        exp_q = '{8'h01, 8'h06, 8'h03, 8'h0C};
        check_bytes("t3");
        repeat (2) @(negedge clk);
        chk("t3_frame_count", frame_count, 16'd2);

        // FIFO fills, fifth round held, then drained in order.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rx_q.delete();
        push_round(4'h1);
        push_round(4'h2);
        push_round(4'h4);
        push_round(4'h8);
        chk("t4_full_ready", round_ready, 1'b0);
        round_data  = 4'hF;
        round_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_held_ready", round_ready, 1'b0);
        chk("t4_busy", busy, 1'b1);
        chk("t4_state_hdr", state, ST_HEADER);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        k = 0;
        while (!round_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!round_ready) timeout_fail("t4_fifth");
        @(posedge clk);
        #1;
        round_valid = 1'b0;
        wait_rx(7, "t4_wait7");
        exp_q = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h01, 8'h08, 8'h0F};
        check_bytes("t4a");
        repeat (3) @(negedge clk);
        chk("t4_starved_valid", out_valid, 1'b0);
        chk("t4_starved_state", state, ST_DATA);
        chk("t4_starved_busy", busy, 1'b1);
        chk("t4_mid_frame_count", frame_count, 16'd3);
        @(posedge clk);
        #1;
        push_round(4'h5);
        wait_rx(8, "t4_wait8");
        exp_q.push_back(8'h05);
        check_bytes("t4b");
        repeat (2) @(negedge clk);
        chk("t4_frame_count", frame_count, 16'd4);

        // Reset after the second data byte of a frame.
        @(posedge clk);
        #1;
        rx_q.delete();
        push_round(4'b0111);
        push_round(4'b0111);
        push_round(4'b0111);
        wait_rx(3, "t5_wait");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_data", out_data, 8'h00);
        chk("t5_rst_frame_count", frame_count, 16'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_state", state, ST_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_before_clk", round_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("t5_ready_after_clk", round_ready, 1'b1);
        rx_q.delete();
        push_round(4'b1001);
        push_round(4'b1001);
        push_round(4'b1001);
        wait_rx(4, "t5_wait_new");
        exp_q = '{8'h01, 8'h09, 8'h09, 8'h09};
        check_bytes("t5");
        repeat (2) @(negedge clk);
        chk("t5_frame_count", frame_count, 16'd1);

        // Two frames with ready toggling every cycle.
        do_reset();
        rx_q.delete();
        fork
            begin
                push_round(4'h3);
                push_round(4'hC);
                push_round(4'h7);
                push_round(4'hE);
                push_round(4'h0);
                push_round(4'hB);
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_rx(8, "t6_wait");
        repeat (4) @(negedge clk);
        exp_q = '{8'h01, 8'h03, 8'h0C, 8'h07, 8'h01, 8'h0E, 8'h00, 8'h0B};
        check_bytes("t6");
        chk("t6_frame_count", frame_count, 16'd2);
        chk("t6_end_valid", out_valid, 1'b0);
        chk("t6_end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
